// File: rtl/mac_seq.sv
// Folded fixed-point MAC: latches one NUM_TAPS vector, accumulates LANES products
// per beat, then rounds (half toward +inf) and optionally saturates to DATA_WIDTH.

module mac_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 67
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  p
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = $signed(a) * $signed(b);
  assign p    = ACC_WIDTH'(prod);
endmodule

module mac_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_FORMAT   = 16,
  parameter int NUM_TAPS   = 8,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(NUM_TAPS),
  parameter bit SATURATE   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inValid,
  output logic                                inReady,
  input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] pDataIn,
  input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] coefs,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [DATA_WIDTH-1:0]               macResult,
  output logic                                overflow,
  output logic                                busy
);
  localparam int NB = NUM_TAPS / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  if (NUM_TAPS % LANES != 0) begin : g_bad_lanes
    $error("mac_seq: LANES must divide NUM_TAPS");
  end
  if (Q_FORMAT < 1 || Q_FORMAT >= DATA_WIDTH) begin : g_bad_q
    $error("mac_seq: Q_FORMAT out of range");
  end

  localparam logic signed [ACC_WIDTH-1:0] RMAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RMIN = ~RMAX;
  localparam logic [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (Q_FORMAT-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  // Reshaped so that beat b selects taps b*LANES .. b*LANES+LANES-1 directly.
  logic [NB-1:0][LANES-1:0][DATA_WIDTH-1:0] data_q, data_d, coef_q, coef_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0]        lane_p [LANES];
  logic [ACC_WIDTH-1:0]        lane_sum, acc_sum, rnd;
  logic signed [ACC_WIDTH-1:0] r;
  logic                        r_hi, r_lo;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .a(data_q[beat_q][g]),
      .b(coef_q[beat_q][g]),
      .p(lane_p[g])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + lane_p[l];
    acc_sum = acc_q + lane_sum;
    rnd     = acc_sum + RND;
    r       = $signed(rnd) >>> Q_FORMAT;
    r_hi    = (r > RMAX);
    r_lo    = (r < RMIN);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (inValid) begin
        data_d  = pDataIn;
        coef_d  = coefs;
        acc_d   = '0;
        beat_d  = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d  = acc_sum;
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(NB-1)) begin
          ovf_d = r_hi | r_lo;
          if (SATURATE && r_hi)      res_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
          else if (SATURATE && r_lo) res_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
          else                       res_d = r[DATA_WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: if (outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      coef_q  <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Reset holds the FSM in IDLE; gate so the upstream never sees ready during reset.
  assign inReady   = rst_n && (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign macResult = res_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: four instances cover saturate/wrap and LANES = 2, 1, 8.
module tb_mac_seq;
  typedef struct { logic [31:0] res; logic ovf; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b1;
  logic [3:0] in_valid = '0, in_ready, out_valid, ovf, busy;
  logic [31:0] res [4];
  logic [7:0][31:0] din = '0, cin = '0;
  exp_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mac_seq #(.SATURATE(1)) u0 (.clk(clk), .rst_n(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .pDataIn(din), .coefs(cin), .outValid(out_valid[0]), .outReady(out_ready),
    .macResult(res[0]), .overflow(ovf[0]), .busy(busy[0]));
  mac_seq #(.SATURATE(0)) u1 (.clk(clk), .rst_n(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .pDataIn(din), .coefs(cin), .outValid(out_valid[1]), .outReady(out_ready),
    .macResult(res[1]), .overflow(ovf[1]), .busy(busy[1]));
  mac_seq #(.LANES(1)) u2 (.clk(clk), .rst_n(rst_n), .inValid(in_valid[2]), .inReady(in_ready[2]),
    .pDataIn(din), .coefs(cin), .outValid(out_valid[2]), .outReady(out_ready),
    .macResult(res[2]), .overflow(ovf[2]), .busy(busy[2]));
  mac_seq #(.LANES(8)) u3 (.clk(clk), .rst_n(rst_n), .inValid(in_valid[3]), .inReady(in_ready[3]),
    .pDataIn(din), .coefs(cin), .outValid(out_valid[3]), .outReady(out_ready),
    .macResult(res[3]), .overflow(ovf[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0][31:0] d, input logic [7:0][31:0] c, input bit sat);
    logic signed [79:0] acc, r;
    logic signed [63:0] p;
    exp_t e;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      p = $signed(d[k]) * $signed(c[k]);
      acc = acc + 80'(p);
    end
    r = (acc + 80'sd32768) >>> 16;
    e.ovf = (r > 80'sd2147483647) || (r < -80'sd2147483648);
    if (e.ovf && sat) e.res = r[79] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else              e.res = r[31:0];
    return e;
  endfunction

  // Hands one vector to instance id; inputs are scrambled right after acceptance.
  task automatic send(input int id, input logic [7:0][31:0] d, input logic [7:0][31:0] c,
                      input bit push, input exp_t e);
    int n = 0;
    @(negedge clk);
    din = d; cin = c; in_valid[id] = 1'b1;
    while (!in_ready[id] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid[id] = 1'b0;
    for (int k = 0; k < 8; k++) begin din[k] = $urandom; cin[k] = $urandom; end
    if (push) sb.push_back(e);
  endtask

  task automatic get(input int id, input int lat, input string tag);
    int cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc == 0) chk({tag, "_busy"}, 32'(busy[id]), 32'd1);
      if (out_valid[id] || cyc > 60) break;
      @(posedge clk); cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    if (sb.size() == 0) begin chk({tag, "_sb_empty"}, 32'd1, 32'd0); return; end
    e = sb.pop_front();
    chk({tag, "_res"}, res[id], e.res);
    chk({tag, "_ovf"}, 32'(ovf[id]), 32'(e.ovf));
    @(posedge clk);
  endtask

  initial begin
    logic [7:0][31:0] ramp, ones, d, c;
    exp_t e, none;
    logic [31:0] hold_res;
    logic hold_ovf;
    none.res = '0; none.ovf = 1'b0;
    for (int k = 0; k < 8; k++) begin ramp[k] = 32'(k+1) << 16; ones[k] = 32'h0001_0000; end

    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_res", res[i], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    e.res = 32'h0024_0000; e.ovf = 1'b0;
    send(0, ramp, ones, 1, e); get(0, 4, "ramp");

    for (int k = 0; k < 8; k++) begin c[k] = 32'h0000_3333; d[k] = 32'h0005_0000; end
    e.res = 32'h0007_FFF8; e.ovf = 1'b0;
    send(0, d, c, 1, e); get(0, 4, "p2x5");
    for (int k = 0; k < 8; k++) d[k] = 32'hFFEC_0000;
    e.res = 32'hFFE0_0020;
    send(0, d, c, 1, e); get(0, 4, "p2xm20");

    d = '0; c = '0; c[0] = 32'h0000_8000; d[0] = 32'h0000_0001;
    e.res = 32'h0000_0001;
    send(0, d, c, 1, e); get(0, 4, "rnd_up");
    d[0] = 32'hFFFF_FFFF; e.res = 32'h0000_0000;
    send(0, d, c, 1, e); get(0, 4, "rnd_neg");

    for (int k = 0; k < 8; k++) d[k] = 32'd30000 << 16;
    e.res = 32'h7FFF_FFFF; e.ovf = 1'b1;
    send(0, d, ones, 1, e); get(0, 4, "sat_pos");
    e.res = 32'hA980_0000;
    send(1, d, ones, 1, e); get(1, 4, "wrap_pos");
    for (int k = 0; k < 8; k++) d[k] = -(32'd30000 << 16);
    e.res = 32'h8000_0000;
    send(0, d, ones, 1, e); get(0, 4, "sat_neg");
    e.res = 32'h5680_0000;
    send(1, d, ones, 1, e); get(1, 4, "wrap_neg");

    for (int k = 0; k < 8; k++) begin d[k] = $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000; c[k] = $urandom; end
    send(0, d, c, 1, model(d, c, 1'b1)); get(0, 4, "rand_sat");
    send(1, d, c, 1, model(d, c, 1'b0)); get(1, 4, "rand_wrap");

    // Back-pressure: result must hold while a competing vector is offered.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 32'd30000 << 16;
    e.res = 32'h7FFF_FFFF; e.ovf = 1'b1;
    send(0, d, ones, 1, e); get(0, 4, "bp_first");
    hold_res = res[0]; hold_ovf = ovf[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = ramp; cin = ones; in_valid[0] = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_res", res[0], hold_res);
      chk("bp_ovf", 32'(ovf[0]), 32'(hold_ovf));
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_idle_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_res_hold", res[0], hold_res);
    e.res = 32'h0024_0000; e.ovf = 1'b0;
    send(0, ramp, ones, 1, e); get(0, 4, "bp_next");

    // Abort during beat 2; partial sum is discarded.
    for (int k = 0; k < 8; k++) d[k] = 32'd30000 << 16;
    send(0, d, ones, 0, none);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_ready", 32'(in_ready[0]), 32'd0);
    chk("mid_rst_res", res[0], 32'd0);
    chk("mid_rst_ovf", 32'(ovf[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    e.res = 32'h0024_0000; e.ovf = 1'b0;
    send(0, ramp, ones, 1, e); get(0, 4, "post_rst");
    send(2, ramp, ones, 1, e); get(2, 8, "lanes1");
    send(3, ramp, ones, 1, e); get(3, 1, "lanes8");
    send(3, d, ones, 1, model(d, ones, 1'b1)); get(3, 1, "lanes8_sat");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Folded, handshaked successor to the combinational FIR MAC.
- Accepts one vector of NUM_TAPS Q-format samples and coefficients over a valid/ready interface.
- Accumulates LANES products per cycle over NUM_TAPS/LANES beats, then rounds to DATA_WIDTH.
- Optionally saturates, and returns the result over a valid/ready output with overflow flag.
- Sits between the FIR tap-delay line and the output stage; the parallelism/area trade is set by LANES.

Parameters:
DATA_WIDTH, 32, sample/coef/result width, signed two's complement
Q_FORMAT, 16, fractional bits (Q16.16 at defaults); must be >=1 and <DATA_WIDTH
NUM_TAPS, 8, taps per vector
LANES, 2, multipliers per cycle; must divide NUM_TAPS (elaboration error otherwise)
ACC_WIDTH, 2*DATA_WIDTH+$clog2(NUM_TAPS), accumulator width
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (truncate)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
inValid  in  1  input vector valid
inReady  out  1  block can accept a vector
pDataIn  in  NUM_TAPS x DATA_WIDTH  signed samples, Q_FORMAT fraction
coefs  in  NUM_TAPS x DATA_WIDTH  signed coefficients, Q_FORMAT fraction
outValid  out  1  macResult valid
outReady  in  1  downstream accepts result
macResult  out  DATA_WIDTH  signed rounded result, Q_FORMAT fraction
overflow  out  1  result exceeded DATA_WIDTH signed range; qualified by outValid
busy  out  1  high in ACCUM or DONE

Behaviour:
- One clock domain: clk. rst_n is asynchronous assert, synchronous deassert (sync'd upstream), active-low.
- Reset values: state IDLE, outValid 0, macResult 0, overflow 0, busy 0, accumulator 0, beat counter 0. inReady is 0 while rst_n is low.
- FSM IDLE:
  - inReady=1.
  - On inValid&&inReady: register all of pDataIn and coefs, clear acc, set beat=0, go to ACCUM.
  - Inputs are not sampled at any other time.
- FSM ACCUM:
  - inReady=0.
  - Each cycle: acc += sum of coefs[k]*pDataIn[k] for k = beat*LANES .. beat*LANES+LANES-1, sign-extended to ACC_WIDTH.
  - beat++. On the last beat (NUM_TAPS/LANES-1), compute the result from the final sum and go to DONE.
- Result computation:
  - r = (acc_final + 2^(Q_FORMAT-1)) >>> Q_FORMAT, arithmetic shift. This is round-half-toward-+inf.
  - If r > 2^(DATA_WIDTH-1)-1 or r < -2^(DATA_WIDTH-1): overflow=1.
    - SATURATE=1: macResult = max or min respectively.
    - SATURATE=0: macResult = r[DATA_WIDTH-1:0].
  - Otherwise overflow=0 and macResult = r[DATA_WIDTH-1:0].
- FSM DONE:
  - outValid=1. macResult and overflow are held stable until outValid&&outReady.
  - On outValid&&outReady: go to IDLE. outValid drops the next cycle; macResult holds its last value.
- Latency: acceptance at edge N gives outValid high after edge N+NUM_TAPS/LANES (4 cycles at defaults).
  - Throughput is one vector per NUM_TAPS/LANES+2 cycles with outReady tied high.
- Back-pressure: outReady low holds DONE indefinitely. inReady stays 0 and inValid is ignored (no vector lost or queued).
- Input stability: changes on pDataIn/coefs after acceptance must not affect the result.
- Reset mid-operation: rst_n low in any state aborts immediately to reset values. The partial accumulation is discarded. The first vector after release computes correctly.
- LANES=NUM_TAPS: a single ACCUM beat (latency 1). LANES=1: NUM_TAPS beats.
- No overflow is possible inside the accumulator at the given ACC_WIDTH.

Test Plan:
- Coefs all 1.0 (0x00010000), pDataIn 1.0..8.0 -> macResult 36.0 (0x00240000), overflow 0; outValid rises exactly 4 cycles after the handshake edge.
- Coefs all 0.2 (0x00003333), data all 5.0 -> 0x0007FFF8 (7.99988); data all -20.0 -> 0xFFE00020 (-31.99951).
- Rounding: coef[0]=0.5 (0x8000), pDataIn[0]=0x00000001, rest 0 -> 0x00000001; pDataIn[0]=0xFFFFFFFF -> 0x00000000.
- Saturation: coefs 1.0, data all 30000.0 -> 0x7FFFFFFF, overflow 1; data all -30000.0 -> 0x80000000, overflow 1. Repeat with SATURATE=0 -> wrapped bits, overflow 1.
- Back-pressure: hold outReady low 5 cycles while driving inValid with a new vector -> outValid, macResult and overflow stable, inReady 0, new vector ignored. Release -> IDLE, next vector accepted and correct.
- Reset mid-ACCUM: pull rst_n low at beat 2 -> outputs at reset values asynchronously. After release, vector 1.0..8.0 with coefs 1.0 -> 36.0. Sweep LANES=1,8 with the same vector -> 36.0 with latency 8 and 1.
